btn_rgb_pwm: RTL

BTN_RGB_PWM -- requirements
Module: btn_rgb_pwm

---
 rtl/btn_rgb_pwm_if.sv | 23 ++
 rtl/btn_rgb_pwm.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/btn_rgb_pwm_if.sv
// rtl/btn_rgb_pwm_if.sv - button inputs, status outputs and RGB PWM drive bundle
interface btn_rgb_pwm_if #(
   parameter int N_BTN = 2
);
   logic [N_BTN-1:0] BTN;
   logic [1:0]       LED;
   logic [1:0]       MODE;
   logic             RGB0_Red;
   logic             RGB0_Green;
   logic             RGB0_Blue;

   // Stimulus side: drives the buttons, observes the indicators.
   modport master (
      output BTN,
      input  LED, MODE, RGB0_Red, RGB0_Green, RGB0_Blue
   );

   // Design side: samples the buttons, drives the indicators.
   modport slave (
      input  BTN,
      output LED, MODE, RGB0_Red, RGB0_Green, RGB0_Blue
   );
endinterface

// File: rtl/btn_rgb_pwm.sv
// rtl/btn_rgb_pwm.sv - debounced buttons select an RGB channel and step its PWM brightness (option macro: BTN_RGB_PWM_DEBOUNCE_EN)
module btn_rgb_pwm #(
   parameter int N_BTN  = 2,
   parameter int PWM_W  = 8,
   parameter int DB_CNT = 50000,
   parameter int STEP   = 32
) (
   input  logic       CLK,
   input  logic       RESET_N,
   btn_rgb_pwm_if.slave bus
);
   // Only buttons 0..2 have a control role; higher ones feed LED only.
   localparam int NP = (N_BTN < 3) ? N_BTN : 3;
   localparam logic [PWM_W-1:0] STEP_W = PWM_W'(STEP);

   typedef enum logic [1:0] {
      SEL_R = 2'd0,
      SEL_G = 2'd1,
      SEL_B = 2'd2
   } sel_t;

   logic [N_BTN-1:0] sync1, sync2, deb;
   logic [NP-1:0]    deb_prev, press_q;
   logic             dec_pulse;
   sel_t             state_q, state_d;
   logic [PWM_W-1:0] lvl_r, lvl_g, lvl_b;
   logic [PWM_W-1:0] pwm_cnt;

   // Two-flop synchroniser for the asynchronous button inputs.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= bus.BTN;
         sync2 <= sync1;
      end
   end

`ifdef BTN_RGB_PWM_DEBOUNCE_EN
   localparam int CW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;

   for (genvar i = 0; i < N_BTN; i++) begin : g_db
      logic [CW-1:0] cnt;
      logic          deb_r;

      // Accept a change only after DB_CNT consecutive cycles of disagreement.
      always_ff @(posedge CLK or negedge RESET_N) begin
         if (!RESET_N) begin
            cnt   <= '0;
            deb_r <= 1'b0;
         end else if (sync2[i] == deb_r) begin
            cnt <= '0;
         end else if (cnt == CW'(DB_CNT - 1)) begin
            deb_r <= ~deb_r;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end

      assign deb[i] = deb_r;
   end
`else
   assign deb = sync2;
`endif

   // Registered rising-edge detect on the debounced control buttons.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         deb_prev <= '0;
         press_q  <= '0;
      end else begin
         deb_prev <= deb[NP-1:0];
         press_q  <= deb[NP-1:0] & ~deb_prev;
      end
   end

   if (NP >= 3) begin : g_dec
      assign dec_pulse = press_q[NP-1];
   end else begin : g_no_dec
      assign dec_pulse = 1'b0;
   end

   // LED[0] = all pressed, LED[1] = any pressed, one cycle behind debounce.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) bus.LED <= 2'b00;
      else          bus.LED <= {|deb, &deb};
   end

   // Mode state register.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) state_q <= SEL_R;
      else          state_q <= state_d;
   end

   // Mode next state: rotate R->G->B on a BTN[0] press, recover from code 3.
   always_comb begin
      state_d = state_q;
      case (state_q)
         SEL_R:   if (press_q[0]) state_d = SEL_G;
         SEL_G:   if (press_q[0]) state_d = SEL_B;
         SEL_B:   if (press_q[0]) state_d = SEL_R;
         default: state_d = SEL_R;
      endcase
   end

   assign bus.MODE = state_q;

   // Step the channel selected before any same-cycle mode advance; inc+dec cancel.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         lvl_r <= '0;
         lvl_g <= '0;
         lvl_b <= '0;
      end else if (press_q[1] ^ dec_pulse) begin
         case (state_q)
            SEL_R:   lvl_r <= press_q[1] ? lvl_r + STEP_W : lvl_r - STEP_W;
            SEL_G:   lvl_g <= press_q[1] ? lvl_g + STEP_W : lvl_g - STEP_W;
            SEL_B:   lvl_b <= press_q[1] ? lvl_b + STEP_W : lvl_b - STEP_W;
            default: ;
         endcase
      end
   end

   // Free-running PWM counter shared by all three channels.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) pwm_cnt <= '0;
      else          pwm_cnt <= pwm_cnt + 1'b1;
   end

   // Registered compare; a new level applies on the very next compare.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         bus.RGB0_Red   <= 1'b0;
         bus.RGB0_Green <= 1'b0;
         bus.RGB0_Blue  <= 1'b0;
      end else begin
         bus.RGB0_Red   <= pwm_cnt < lvl_r;
         bus.RGB0_Green <= pwm_cnt < lvl_g;
         bus.RGB0_Blue  <= pwm_cnt < lvl_b;
      end
   end
endmodule
